// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bus: raw pin inputs, receive enable, and the decoded byte/strobe outputs.
// master = host side driving the pins, slave = the receiver.
interface ps2_rx_frame_if;
    logic       PS2C;
    logic       PS2D;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output PS2C, PS2D, rx_en,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  PS2C, PS2D, rx_en,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronises and de-glitches PS2C/PS2D, frames 11-bit packets,
// checks odd parity and stop bit, and strobes each good byte for one cycle.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 200000
) (
    input  logic           clk,
    input  logic           clr,
    ps2_rx_frame_if.slave  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic                  c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] taps;
    logic                  filt_c, filt_next, fall_tick;

    state_t                state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit;
    logic [TW-1:0]         to_cnt;
    logic [7:0]            rx_data;
    logic                  rx_valid, parity_err, frame_err, busy;

    // Filtered clock only moves when every tap agrees; mixed taps hold the previous level.
    always_comb begin
        filt_next = filt_c;
        if (taps == '0)
            filt_next = 1'b0;
        else if (taps == '1)
            filt_next = 1'b1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            c_s1      <= 1'b1;
            c_s2      <= 1'b1;
            d_s1      <= 1'b1;
            d_s2      <= 1'b1;
            taps      <= '1;
            filt_c    <= 1'b1;
            fall_tick <= 1'b0;
        end else begin
            c_s1      <= bus.PS2C;
            c_s2      <= c_s1;
            d_s1      <= bus.PS2D;
            d_s2      <= d_s1;
            taps      <= {taps[FILTER_LEN-2:0], c_s2};
            filt_c    <= filt_next;
            fall_tick <= filt_c & ~filt_next;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall_tick)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;

            // A stalled device clock abandons the partial frame before any edge is considered.
            if (state != IDLE && to_cnt == TO_MAX) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
            end else if (fall_tick) begin
                case (state)
                    IDLE: begin
                        if (!d_s2 && bus.rx_en) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {d_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= d_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!d_s2)
                            frame_err <= 1'b1;
                        else if (^{shreg, par_bit}) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else
                            parity_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.busy       = busy;

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- PS/2 device-to-host serial receiver. It sits directly upstream of the keyboard scan-code decoder that drives U/L/R/D into control.
- Synchronises and de-glitches the raw PS2C/PS2D pins and frames each 11-bit PS/2 packet.
- Checks odd parity and the stop bit, then presents each good byte as a one-cycle strobe.
- Runs on the board system clock (100 MHz). It does not use clk_n.

Parameters:
FILTER_LEN, 8, consecutive identical PS2C samples required before the filtered clock changes (range 2..16)
TIMEOUT, 200000, clk cycles allowed between filtered PS2C falling edges inside a frame (2 ms at 100 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  reset, asynchronous, active-low (clr=0 resets)
PS2C  input  1  raw PS/2 clock pin, asynchronous
PS2D  input  1  raw PS/2 data pin, asynchronous
rx_en  input  1  1 = accept new frames; 0 = ignore start bits while IDLE
rx_data  output  8  last good byte, LSB = first data bit received
rx_valid  output  1  one-cycle pulse, rx_data updated this cycle
parity_err  output  1  one-cycle pulse, frame dropped on bad parity
frame_err  output  1  one-cycle pulse, frame dropped on bad stop bit or timeout
busy  output  1  1 while state != IDLE

Behaviour:
Reset (clr=0, asynchronous):
- rx_data=8'h00; rx_valid, parity_err, frame_err, busy = 0.
- State = IDLE; synchronisers and filtered clock = 1; bit counter and timeout counter = 0.

Input conditioning:
- PS2C and PS2D each pass through a 2-FF synchroniser.
- Filter on PS2C: a FILTER_LEN-deep shift register. filt_c becomes 0 only when all taps are 0 and becomes 1 only when all taps are 1; otherwise it holds its value.
- fall_tick is a registered one-cycle pulse on a 1->0 transition of filt_c.
- Data is sampled from synchronised PS2D in the fall_tick cycle.

State machine (advances only on fall_tick, except for timeout):
- IDLE:
  - Sampled 0 with rx_en=1 -> DATA, bit counter = 0.
  - Sampled 1, or rx_en=0 -> stay in IDLE.
- DATA: shift the sample into the shift register LSB-first. After the 8th bit -> PARITY.
- PARITY: store the parity bit -> STOP.
- STOP: evaluate on this fall_tick, then -> IDLE.
  - Stop sample=1 and odd parity OK (XOR of 8 data bits and parity bit = 1): rx_data <= shift register, rx_valid=1 for 1 cycle.
  - Stop sample=1 and parity bad: parity_err=1 for 1 cycle; rx_data unchanged.
  - Stop sample=0: frame_err=1 for 1 cycle, regardless of parity.

Strobe timing:
- Strobes assert in the cycle after the STOP-state fall_tick.
- At most one of rx_valid, parity_err, frame_err is ever high in a cycle.

Timeout:
- The timeout counter clears on every fall_tick and while in IDLE; otherwise it increments and saturates.
- When it reaches TIMEOUT while state != IDLE: frame_err pulses, state -> IDLE, partial data is discarded.

Other rules:
- rx_en deasserted mid-frame does not abort the current frame; it only blocks the next start bit.
- Back-to-back frames: a start bit on the first fall_tick after returning to IDLE is accepted; there is no dead time.
- Reset mid-frame: immediate return to IDLE with all outputs 0.
- rx_data holds its value between good frames.
- busy is 0 in IDLE, 1 in DATA, PARITY and STOP.

Test Plan:
1. Good frame: send 0x1D (bits 1,0,1,1,1,0,0,0, parity 1, stop 1) at a 12.5 kHz PS2C -> exactly one rx_valid, rx_data=8'h1D, no error pulses; busy returns to 0.
2. Parity error: send 0x75 with parity bit 1 (correct is 0) -> parity_err pulse once, rx_valid stays 0, rx_data keeps its previous value 8'h1D.
3. Glitch rejection: inject a 5-cycle low pulse on PS2C (< FILTER_LEN=8) in IDLE and mid-DATA -> no fall_tick, bit count unchanged, frame 0xF0 still received correctly.
4. Timeout: stop PS2C after 4 data bits -> frame_err pulse 200000 cycles (±FILTER_LEN+4) after the last edge, busy=0; a following 0x6B frame gives rx_data=8'h6B.
5. Bad stop bit: send 0xE0 with stop=0 -> frame_err once, no rx_valid.
6. Control: with rx_en=0, send 0x72 -> no strobes, busy stays 0. Drop rx_en mid-frame of 0x74 -> frame completes, rx_data=8'h74. Assert clr=0 mid-frame -> all outputs 0 asynchronously, and the next full frame is received cleanly.
